// File: rtl/merged_perm_pkg.sv
// Shared definitions for the merged (un)permutation blocks: mode encodings,
// fill/drain state type and the address-width helper.
package merged_perm_pkg;

  typedef enum logic [1:0] {
    PERM_IDENTITY  = 2'd0,
    PERM_RADER_IN  = 2'd1,
    PERM_RADER_OUT = 2'd2,
    PERM_REVERSE   = 2'd3
  } perm_mode_e;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Bits needed to address a buffer of 'size' entries (never less than one).
  function automatic int addr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/unperm_addr_gen.sv
// Write-address generator for merged_unpermutation: holds the latched mode and
// the scatter address of the current input beat.
module unperm_addr_gen
  import merged_perm_pkg::*;
#(
  parameter int SIZE  = 257,
  parameter int G     = 3,
  parameter int G_INV = 86,
  parameter int AW    = addr_width(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic          clear,
  input  logic [1:0]    mode_in,
  output logic [AW-1:0] addr
);

  localparam int CW = addr_width(((G > G_INV) ? G : G_INV) + 1);
  localparam int PW = AW + CW;
  localparam logic [PW-1:0] G_W    = PW'(G);
  localparam logic [PW-1:0] GINV_W = PW'(G_INV);
  localparam logic [PW-1:0] SIZE_W = PW'(SIZE);
  localparam logic [AW-1:0] LAST_A = AW'(SIZE - 1);

  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_n_s;
  perm_mode_e    mode_r;
  perm_mode_e    mode_n_s;
  logic [PW-1:0] mult_s;
  logic [PW-1:0] prod_s;
  logic [PW-1:0] mod_s;

  // Next address: beat 0 always lands on 0, beat 1 seeds the mode's sequence.
  always_comb begin
    mult_s   = (mode_r == PERM_RADER_OUT) ? GINV_W : G_W;
    prod_s   = PW'(addr_r) * mult_s;
    mod_s    = prod_s % SIZE_W;
    addr_n_s = addr_r;
    mode_n_s = mode_r;
    if (clear) begin
      addr_n_s = {AW{1'b0}};
    end else if (load) begin
      mode_n_s = perm_mode_e'(mode_in);
      addr_n_s = (perm_mode_e'(mode_in) == PERM_REVERSE) ? LAST_A : AW'(1);
    end else if (step) begin
      case (mode_r)
        PERM_IDENTITY:  addr_n_s = addr_r + AW'(1);
        PERM_RADER_IN:  addr_n_s = mod_s[AW-1:0];
        PERM_RADER_OUT: addr_n_s = mod_s[AW-1:0];
        PERM_REVERSE:   addr_n_s = (addr_r == {AW{1'b0}}) ? LAST_A : addr_r - AW'(1);
        default:        addr_n_s = addr_r;
      endcase
    end else begin
      addr_n_s = addr_r;
    end
  end

  // Address and latched-mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {AW{1'b0}};
      mode_r <= PERM_IDENTITY;
    end else begin
      addr_r <= addr_n_s;
      mode_r <= mode_n_s;
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/merged_unpermutation.sv
// Streaming inverse of the merged NTT permutation: scatter a frame into a
// register buffer, then drain it in natural order.
// Define MERGED_UNPERM_PINGPONG_EN for two banks (fill overlaps drain).
module merged_unpermutation
  import merged_perm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 257,
  parameter int G     = 3,
  parameter int G_INV = 86
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_perm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int AW = addr_width(SIZE);
  localparam logic [AW-1:0] LAST_A = AW'(SIZE - 1);
`ifdef MERGED_UNPERM_PINGPONG_EN
  localparam int   NB      = 2;
  localparam logic BANK_TG = 1'b1;
`else
  localparam int   NB      = 1;
  localparam logic BANK_TG = 1'b0;
`endif

  logic [WIDTH-1:0] mem_r [NB][SIZE];

  state_e           bank_state_r [NB];
  state_e           bank_state_n_s [NB];
  logic             wr_bank_r, wr_bank_n_s;
  logic             rd_bank_r, rd_bank_n_s;
  logic [AW-1:0]    wr_cnt_r, wr_cnt_n_s;
  logic [AW-1:0]    rd_ptr_r, rd_ptr_n_s;
  logic             in_ready_r, in_ready_n_s;
  logic             out_valid_r, out_valid_n_s;
  logic             out_last_r, out_last_n_s;
  logic [WIDTH-1:0] out_data_r, out_data_n_s;
  logic [WIDTH-1:0] rd_word_s;
  logic             in_acc_s, out_acc_s, in_last_s, out_end_s;
  logic [AW-1:0]    wr_addr_s;

  assign in_acc_s  = in_valid && in_ready_r;
  assign out_acc_s = out_valid_r && out_ready;
  assign in_last_s = in_acc_s && (wr_cnt_r == LAST_A);
  assign out_end_s = out_acc_s && (rd_ptr_r == LAST_A);

  unperm_addr_gen #(
    .SIZE  (SIZE),
    .G     (G),
    .G_INV (G_INV),
    .AW    (AW)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (in_acc_s && (wr_cnt_r == {AW{1'b0}})),
    .step    (in_acc_s),
    .clear   (in_last_s),
    .mode_in (in_perm),
    .addr    (wr_addr_s)
  );

  // Bank FSMs, pointers and the look-ahead output word.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      bank_state_n_s[b] = bank_state_r[b];
    end
    if (in_last_s) begin
      bank_state_n_s[wr_bank_r] = ST_DRAIN;
    end else begin
      bank_state_n_s[wr_bank_r] = bank_state_r[wr_bank_r];
    end
    if (out_end_s) begin
      bank_state_n_s[rd_bank_r] = ST_FILL;
    end else begin
      bank_state_n_s[rd_bank_r] = bank_state_n_s[rd_bank_r];
    end
    wr_bank_n_s = in_last_s ? (wr_bank_r ^ BANK_TG) : wr_bank_r;
    rd_bank_n_s = out_end_s ? (rd_bank_r ^ BANK_TG) : rd_bank_r;
    if (in_last_s) begin
      wr_cnt_n_s = {AW{1'b0}};
    end else if (in_acc_s) begin
      wr_cnt_n_s = wr_cnt_r + AW'(1);
    end else begin
      wr_cnt_n_s = wr_cnt_r;
    end
    if (out_end_s) begin
      rd_ptr_n_s = {AW{1'b0}};
    end else if (out_acc_s) begin
      rd_ptr_n_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_n_s = rd_ptr_r;
    end
    in_ready_n_s  = (bank_state_n_s[wr_bank_n_s] == ST_FILL);
    out_valid_n_s = (bank_state_n_s[rd_bank_n_s] == ST_DRAIN);
    out_last_n_s  = out_valid_n_s && (rd_ptr_n_s == LAST_A);
    // The word written this cycle is not yet in mem_r, so forward it.
    if (in_acc_s && (wr_bank_r == rd_bank_n_s) && (wr_addr_s == rd_ptr_n_s)) begin
      rd_word_s = in_data;
    end else begin
      rd_word_s = mem_r[rd_bank_n_s][rd_ptr_n_s];
    end
    out_data_n_s = out_valid_n_s ? rd_word_s : {WIDTH{1'b0}};
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        bank_state_r[b] <= ST_FILL;
      end
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_cnt_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else begin
      for (int b = 0; b < NB; b++) begin
        bank_state_r[b] <= bank_state_n_s[b];
      end
      wr_bank_r   <= wr_bank_n_s;
      rd_bank_r   <= rd_bank_n_s;
      wr_cnt_r    <= wr_cnt_n_s;
      rd_ptr_r    <= rd_ptr_n_s;
      in_ready_r  <= in_ready_n_s;
      out_valid_r <= out_valid_n_s;
      out_last_r  <= out_last_n_s;
      out_data_r  <= out_data_n_s;
    end
  end

  // Coefficient buffer; deliberately not reset.
  always_ff @(posedge clk) begin
    if (in_acc_s) begin
      mem_r[wr_bank_r][wr_addr_s] <= in_data;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_merged_unpermutation.sv
// Self-checking bench for merged_unpermutation (SIZE=7, G=3, G_INV=5) with a
// scatter-by-modular-power reference model.
module tb_merged_unpermutation;

  localparam int W  = 32;
  localparam int S  = 7;
  localparam int GG = 3;
  localparam int GI = 5;

  typedef logic [W-1:0] frame_t [S];

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_perm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  int n_vec = 0;
  int n_err = 0;

  merged_unpermutation #(
    .WIDTH (W),
    .SIZE  (S),
    .G     (GG),
    .G_INV (GI)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_perm   (in_perm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int modpow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % S;
    return r;
  endfunction

  // Output frame = input frame scattered to a_k, read back in natural order.
  function automatic void model(input int mode, input frame_t d, output frame_t e);
    int a;
    for (int k = 0; k < S; k++) begin
      case (mode)
        0:       a = k;
        1:       a = (k == 0) ? 0 : modpow(GG, k - 1);
        2:       a = (k == 0) ? 0 : modpow(GI, k - 1);
        default: a = (S - k) % S;
      endcase
      e[a] = d[k];
    end
  endfunction

  task automatic send_frame(input int mode, input frame_t d, input bit scramble, output int stalls);
    stalls = 0;
    for (int k = 0; k < S; k++) begin
      int  guard = 0;
      bit  acc   = 1'b0;
      in_valid = 1'b1;
      in_data  = d[k];
      in_perm  = (k == 0 || !scramble) ? 2'(mode) : 2'd0;
      while (!acc && guard < 200) begin
        acc = in_ready;
        @(posedge clk); #1;
        if (!acc) stalls++;
        guard++;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    in_perm  = 2'($urandom_range(0, 3));
  endtask

  task automatic collect_frame(input string tag, input frame_t e, input int stall_at, input int stall_len);
    for (int j = 0; j < S; j++) begin
      if (j == 0) begin
        int guard = 0;
        while (!out_valid && guard < 200) begin
          @(posedge clk); #1;
          guard++;
        end
      end
      chk($sformatf("%s_valid%0d", tag, j), {31'd0, out_valid}, 32'd1);
      chk($sformatf("%s_data%0d", tag, j), out_data, e[j]);
      chk($sformatf("%s_last%0d", tag, j), {31'd0, out_last}, (j == S - 1) ? 32'd1 : 32'd0);
`ifndef MERGED_UNPERM_PINGPONG_EN
      chk($sformatf("%s_inrdy%0d", tag, j), {31'd0, in_ready}, 32'd0);
`endif
      if (j == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk); #1;
          chk($sformatf("%s_hold%0d", tag, j), out_data, e[j]);
          chk($sformatf("%s_holdv%0d", tag, j), {31'd0, out_valid}, 32'd1);
`ifndef MERGED_UNPERM_PINGPONG_EN
          chk($sformatf("%s_holdrdy%0d", tag, j), {31'd0, in_ready}, 32'd0);
`endif
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    frame_t d, e, tbl [4];
    int st, mode, sat, slen;

    tbl[0] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    tbl[1] = '{32'd0, 32'd1, 32'd3, 32'd2, 32'd5, 32'd6, 32'd4};
    tbl[2] = '{32'd0, 32'd1, 32'd5, 32'd6, 32'd3, 32'd2, 32'd4};
    tbl[3] = '{32'd0, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    for (int k = 0; k < S; k++) d[k] = W'(k);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_perm = 2'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed frames, in_data = k, every mode.
    for (int m = 3; m >= 0; m--) begin
      int mm = (m + 1) % 4;
      send_frame(mm, d, 1'b0, st);
      chk($sformatf("lat_valid_m%0d", mm), {31'd0, out_valid}, 32'd1);
      chk($sformatf("lat_data_m%0d", mm), out_data, 32'd0);
      collect_frame($sformatf("dir_m%0d", mm), tbl[mm], -1, 0);
      chk($sformatf("end_valid_m%0d", mm), {31'd0, out_valid}, 32'd0);
      chk($sformatf("end_inrdy_m%0d", mm), {31'd0, in_ready}, 32'd1);
    end

    // in_perm changes after beat 0 must be ignored; stall mid-drain.
    send_frame(1, d, 1'b1, st);
    collect_frame("scramble", tbl[1], 3, 3);

    // Reset mid-frame discards partial input.
    in_valid = 1'b1; in_perm = 2'd1;
    for (int k = 0; k < 4; k++) begin
      in_data = W'(k + 50);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_out_last", {31'd0, out_last}, 32'd0);
    chk("mrst_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(3, d, 1'b0, st);
    collect_frame("post_rst", tbl[3], -1, 0);

    // Randomized frames against the model.
    for (int f = 0; f < 10; f++) begin
      frame_t rd;
      mode = $urandom_range(0, 3);
      for (int k = 0; k < S; k++) rd[k] = $urandom;
      model(mode, rd, e);
      sat  = $urandom_range(0, S - 1);
      slen = $urandom_range(0, 3);
      send_frame(mode, rd, f[0], st);
      collect_frame($sformatf("rnd%0d_m%0d", f, mode), e, sat, slen);
    end

`ifdef MERGED_UNPERM_PINGPONG_EN
    // Back-to-back frames: no input stall, no output gap.
    begin
      frame_t db, ea, eb;
      for (int k = 0; k < S; k++) db[k] = W'(k + 100);
      model(1, d, ea);
      model(3, db, eb);
      fork
        begin
          int sa, sb;
          send_frame(1, d, 1'b0, sa);
          send_frame(3, db, 1'b0, sb);
          chk("pp_stalls", 32'(sa + sb), 32'd0);
        end
        begin
          collect_frame("pp_a", ea, -1, 0);
          chk("pp_nogap", {31'd0, out_valid}, 32'd1);
          collect_frame("pp_b", eb, -1, 0);
        end
      join
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
